// File: rtl/dt_estimator_mc.sv
// dt_estimator_mc: per-channel EMA of T[n]-T[n-1] with scale, clamp and re-init.
// Ports: clk/rst_n (async active-low); s_valid/s_ready/s_ch/s_T input sample stream;
// alpha (EMA weight /256), k_dt (delta divide by 2^k_dt), d_max (clamp magnitude);
// init_mask (per-channel re-init pulses); m_valid/m_ready/m_ch/m_dT/m_sat/m_primed result stream.
module dt_estimator_mc #(
  parameter int N_CH = 4,
  parameter int W_IN = 8,
  parameter int F = 8,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int W_S = W_IN + F + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [CH_W-1:0]        s_ch,
  input  logic signed [W_IN-1:0] s_T,
  input  logic [7:0]             alpha,
  input  logic [3:0]             k_dt,
  input  logic [W_IN-2:0]        d_max,
  input  logic [N_CH-1:0]        init_mask,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CH_W-1:0]        m_ch,
  output logic signed [W_IN-1:0] m_dT,
  output logic                   m_sat,
  output logic                   m_primed
);
  localparam int W_P = W_S + 11;
  logic signed [W_IN-1:0] t_prev [N_CH];
  logic signed [W_S-1:0]  st [N_CH];
  logic [N_CH-1:0]        primed;
  logic                   rdy_q, stall, adv, acc, in_rng, pr, kill_now;
  logic                   p1_valid, p1_prim, p1_kill;
  logic [CH_W-1:0]        p1_ch;
  logic signed [W_S-1:0]  p1_ds, p1_dp, ds, fwd, nclamp;
  logic signed [W_IN:0]   delta;
  logic [4:0]             k_eff;
  logic [8:0]             a_inv;
  logic signed [W_P-1:0]  mix, shr, lim, nlim, cl;
  logic                   sat_n;
  assign stall   = m_valid && !m_ready;
  assign adv     = !stall;
  assign s_ready = rdy_q && !stall;
  assign acc     = s_valid && s_ready;
  assign in_rng  = 32'(s_ch) < N_CH;
  // Stage 1: scaled delta, and the previous state for this channel
  assign k_eff = (32'(k_dt) > F + W_IN) ? 5'(F + W_IN) : 5'(k_dt);
  assign delta = (W_IN+1)'(s_T) - (W_IN+1)'(t_prev[s_ch]);
  assign ds    = $signed({delta, {F{1'b0}}}) >>> k_eff;
  assign pr    = primed[s_ch] && !init_mask[s_ch];
  // A result killed by init must neither write back nor forward
  assign kill_now = p1_kill || init_mask[p1_ch];
  assign fwd = (p1_valid && p1_ch == s_ch && !kill_now) ? nclamp : st[s_ch];
  // Stage 2: weighted mix, floor shift, symmetric clamp
  assign a_inv = 9'(16'd256 - 16'(alpha));
  assign mix   = W_P'(p1_dp) * W_P'($signed({1'b0, a_inv})) + W_P'(p1_ds) * W_P'($signed({1'b0, alpha}));
  assign shr   = mix >>> 8;
  assign lim   = W_P'({d_max, {F{1'b0}}});
  assign nlim  = -lim;
  assign cl    = (shr > lim) ? lim : (shr < nlim) ? nlim : shr;
  assign sat_n = p1_prim && (shr > lim || shr < nlim);
  assign nclamp = p1_prim ? W_S'(cl) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      p1_valid <= 1'b0;
      p1_prim  <= 1'b0;
      p1_kill  <= 1'b0;
      p1_ch    <= '0;
      p1_ds    <= '0;
      p1_dp    <= '0;
      m_valid  <= 1'b0;
      m_ch     <= '0;
      m_dT     <= '0;
      m_sat    <= 1'b0;
      m_primed <= 1'b0;
      primed   <= '0;
      for (int c = 0; c < N_CH; c++) begin
        t_prev[c] <= '0;
        st[c]     <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (adv) begin
        m_valid  <= p1_valid;
        m_ch     <= p1_ch;
        m_dT     <= W_IN'(nclamp >>> F);
        m_sat    <= sat_n;
        m_primed <= p1_prim;
        if (p1_valid && !kill_now) st[p1_ch] <= nclamp;
        p1_valid <= acc && in_rng;
        p1_ch    <= s_ch;
        p1_ds    <= ds;
        p1_dp    <= fwd;
        p1_prim  <= pr;
        p1_kill  <= 1'b0;
      end else begin
        p1_kill <= kill_now;
      end
      for (int c = 0; c < N_CH; c++) begin
        if (init_mask[c]) begin
          primed[c] <= 1'b0;
          st[c]     <= '0;
        end
      end
      // A sample accepted together with init still primes its channel afterwards
      if (acc && in_rng) begin
        t_prev[s_ch] <= s_T;
        primed[s_ch] <= 1'b1;
      end
    end
  end
endmodule

// File: doc/dt_estimator_mc.md
Name: dt_estimator_mc

Overview:
Multi-channel, parametrised successor of the single-channel dT estimator. It computes a per-channel exponential moving average of T[n]-T[n-1], with scale divider, magnitude clamp and per-channel re-initialisation. Samples from N_CH time-multiplexed sensor channels arrive on a valid/ready stream. Results leave on a valid/ready stream after a fixed 2-stage pipeline. The block sits between the sample sequencer and the per-channel control loops (REQ-060..062, REQ-210).

Parameters:
N_CH, 4, number of channels (1..16); CH_W = max(1, clog2(N_CH))
W_IN, 8, signed temperature/dT width (Q(W_IN-1).0)
F, 8, fraction bits of internal state; state width W_S = W_IN + F + 1

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
s_valid  in  1  input sample valid
s_ready  out  1  input accept; transfer when s_valid && s_ready
s_ch  in  CH_W  channel index of sample (values >= N_CH ignored: accepted, dropped)
s_T  in  W_IN  signed temperature sample
alpha  in  8  EMA weight, alpha/256 (quasi-static)
k_dt  in  4  delta scale, divide by 2^k_dt (k_dt > F+W_IN treated as F+W_IN)
d_max  in  W_IN-1  unsigned clamp magnitude, integer units
init_mask  in  N_CH  1-cycle per-channel init pulses
m_valid  out  1  result valid
m_ready  in  1  result accept
m_ch  out  CH_W  channel of result
m_dT  out  W_IN  signed dT estimate, integer units
m_sat  out  1  clamp was active for this result
m_primed  out  1  0 = capture-only sample (dT forced 0)

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0, including m_valid, s_ready and m_dT.
  - Per-channel T_prev, dT_state (W_S signed) and primed are cleared.
  - Pipeline valids are cleared.
  - s_ready rises on the first clk edge after rst_n deasserts.
- Stall: stall = m_valid && !m_ready. s_ready = !stall (registered reset value 0, then combinational). While stalled, all pipeline registers hold and m_* stays stable.
- Stage 1 (accept edge):
  - Read T_prev, dT_state and primed for s_ch.
  - delta = s_T - T_prev, in W_IN+1 bits.
  - delta_s = (delta <<< F) >>> k_dt, arithmetic (floor), in W_S bits.
  - Write T_prev[s_ch] <= s_T and primed[s_ch] <= 1.
- Stage 2:
  - new = (dT_prev*(256-alpha) + delta_s*alpha) >>> 8, arithmetic floor, full-width product with no intermediate overflow.
  - Clamp new to [-(d_max<<F), +(d_max<<F)]. m_sat = 1 when the clamp changed the value.
  - Write dT_state[ch] <= clamped value.
  - m_dT = clamped >>> F (floor); the result always fits in W_IN.
- Latency: the result is valid 2 edges after acceptance, absent stall. Throughput is 1 sample/cycle.
- Unprimed channel: the sample only captures T_prev. dT_state <= 0, m_dT = 0, m_sat = 0, m_primed = 0.
- Hazard, same channel back-to-back: dT_prev for stage 1 is forwarded from the stage-2 result. There are no bubbles, and the result must equal sequential processing.
- init_mask[c] = 1: on that edge, clear primed[c] and dT_state[c]. init is not affected by stall.
  - init together with an accepted sample on channel c: init wins ordering. The sample is treated as unprimed (capture only, m_primed = 0, channel primed afterwards).
  - init while a sample of channel c is in stage 2: that result is still emitted, but its dT_state writeback is suppressed, and it does not forward into a following sample.
- alpha = 0: the state holds. alpha = 255: the state approximately tracks delta_s.
- Out-of-range s_ch: the sample is accepted, no state changes and no output is produced.

Test Plan:
1. Defaults, ch0 with alpha=128, k_dt=0, d_max=127. Send T=0, then T=10, then T=20.
   -> Outputs m_dT = 0 (m_primed=0), 5, 7, each with m_sat=0. The second output 7 confirms the 1280→1920 internal state step.
2. ch1 with alpha=255, d_max=3. Send T=0, then T=100.
   -> Second output has m_dT = 3, m_sat = 1. Then send T=100 with alpha=0 -> m_dT = 3 (state holds).
3. Negative and scale: ch2, alpha=128, k_dt=1. Send T=0, then T=-10.
   -> m_dT = -3 (-640 >>> 8 = -2.5, floored to -3), m_sat = 0.
4. Interleave ch0/ch1/ch0/ch1 every cycle, then ch3 four times back-to-back.
   -> Results match a sequential golden model, with no bubbles and latency of 2.
5. m_ready held low 5 cycles with the pipeline full.
   -> s_ready = 0 and m_* stable. On release, no sample is lost or duplicated.
6. init_mask[0] pulsed in the same cycle as a ch0 sample, and again with ch0 in stage 2. Separately, rst_n is pulsed mid-stream.
   -> The same-cycle sample gives m_primed = 0 and m_dT = 0. The in-flight result is emitted but the next ch0 output is 0. After the reset pulse, all outputs are 0 and the next sample per channel is unprimed.
